// File: rtl/mips_decode_stage.sv
// ID stage: decode, regfile read addressing, EX/WB operand forwarding, load-use detection; 1 cycle IF/ID -> ID/EX.
// stall_in freezes the ID/EX register; stall_out holds PC and IF/ID for the single cycle a load-use needs.
module mips_decode_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic              stall_in,
  input  logic              flush,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0] ex_wr_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_wr_data,
  output logic              stall_out,
  output logic              valid_out,
  output logic [31:0]       pc_out,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [31:0]       imm_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              wr_en_out,
  output logic [5:0]        opcode_out,
  output logic [5:0]        funct_out,
  output logic [4:0]        shamt_out
);

  localparam logic [REG_AW-1:0] LINK = REG_AW'(LINK_REG);

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [31:0]       pc;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [31:0]       imm;
    logic [REG_AW-1:0] rd;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
  } idex_t;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic              uses_rs;
  logic              uses_rt;
  logic              wr_dec;
  logic              zext;
  logic [REG_AW-1:0] rd_dec;
  logic              wr_en_dec;
  logic [31:0]       imm_ext;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              ld_hit;
  logic              bubble;
  idex_t             idex_d;
  idex_t             idex_q;

  assign opcode  = instr_in[31:26];
  assign funct   = instr_in[5:0];
  assign imm16   = instr_in[15:0];
  assign rs_addr = instr_in[25:21];
  assign rt_addr = instr_in[20:16];

  always_comb begin
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    wr_dec  = 1'b0;
    zext    = 1'b0;
    case (opcode)
      6'h00:                      begin uses_rt = 1'b1; wr_dec = (funct != 6'h08); end
      6'h02:                      uses_rs = 1'b0;
      6'h03:                      begin uses_rs = 1'b0; wr_dec = 1'b1; end
      6'h04, 6'h05:               uses_rt = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B: wr_dec = 1'b1;
      6'h0C, 6'h0D, 6'h0E:        begin wr_dec = 1'b1; zext = 1'b1; end
      6'h0F:                      begin uses_rs = 1'b0; wr_dec = 1'b1; end
      6'h20, 6'h21, 6'h22,
      6'h23, 6'h24, 6'h25:        wr_dec = 1'b1;
      6'h28, 6'h29, 6'h2A, 6'h2B: uses_rt = 1'b1;
      default:                    ;
    endcase
  end

  assign rd_dec    = (opcode == 6'h00) ? instr_in[15:11] :
                     (opcode == 6'h03) ? LINK : instr_in[20:16];
  assign wr_en_dec = wr_dec && (rd_dec != '0);
  assign imm_ext   = zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

  // A load in EX has no data yet, so it never forwards; WB also covers the same-edge regfile write.
  always_comb begin
    fwd_a = rs_data;
    if (rs_addr == '0)                                             fwd_a = '0;
    else if (ex_wr_en && !ex_is_load && (ex_wr_addr == rs_addr))   fwd_a = ex_wr_data;
    else if (wb_wr_en && (wb_wr_addr == rs_addr))                  fwd_a = wb_wr_data;

    fwd_b = rt_data;
    if (rt_addr == '0)                                             fwd_b = '0;
    else if (ex_wr_en && !ex_is_load && (ex_wr_addr == rt_addr))   fwd_b = ex_wr_data;
    else if (wb_wr_en && (wb_wr_addr == rt_addr))                  fwd_b = wb_wr_data;
  end

  assign ld_hit    = valid_in && ex_wr_en && ex_is_load && (ex_wr_addr != '0);
  assign stall_out = ld_hit && ((uses_rs && (ex_wr_addr == rs_addr)) ||
                                (uses_rt && (ex_wr_addr == rt_addr)));
  assign bubble    = flush || stall_out;

  always_comb begin
    idex_d        = '0;
    idex_d.valid  = valid_in && !bubble;
    idex_d.wr_en  = wr_en_dec && valid_in && !bubble;
    idex_d.pc     = pc_in;
    idex_d.op_a   = fwd_a;
    idex_d.op_b   = fwd_b;
    idex_d.imm    = imm_ext;
    idex_d.rd     = rd_dec;
    idex_d.opcode = opcode;
    idex_d.funct  = funct;
    idex_d.shamt  = instr_in[10:6];
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else if (!stall_in) begin
      idex_q <= idex_d;
    end
  end

  assign valid_out  = idex_q.valid;
  assign wr_en_out  = idex_q.wr_en;
  assign pc_out     = idex_q.pc;
  assign op_a       = idex_q.op_a;
  assign op_b       = idex_q.op_b;
  assign imm_out    = idex_q.imm;
  assign rd_out     = idex_q.rd;
  assign opcode_out = idex_q.opcode;
  assign funct_out  = idex_q.funct;
  assign shamt_out  = idex_q.shamt;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: directed cases plus random traffic, scoreboarded against a spec-level model
// with a behavioural register file.
module tb_mips_decode_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        stall_in;
  logic        flush;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ex_wr_en;
  logic        ex_is_load;
  logic [4:0]  ex_wr_addr;
  logic [31:0] ex_wr_data;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm_out;
  logic [4:0]  rd_out;
  logic        wr_en_out;
  logic [5:0]  opcode_out;
  logic [5:0]  funct_out;
  logic [4:0]  shamt_out;

  always #5 CLK = ~CLK;

  logic [31:0] rf [32];
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  mips_decode_stage dut (
    .CLK(CLK), .reset(reset), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
    .stall_in(stall_in), .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .wb_wr_en(wb_wr_en),
    .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .stall_out(stall_out),
    .valid_out(valid_out), .pc_out(pc_out), .op_a(op_a), .op_b(op_b), .imm_out(imm_out),
    .rd_out(rd_out), .wr_en_out(wr_en_out), .opcode_out(opcode_out), .funct_out(funct_out),
    .shamt_out(shamt_out)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        ex_en;
    logic        ex_ld;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } stim_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t last_exp = '0;
  logic exp_valid = 1'b0;
  logic last_hz = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t actual();
    exp_t a;
    a.pc = pc_out; a.op_a = op_a; a.op_b = op_b; a.imm = imm_out; a.rd = rd_out;
    a.wr = wr_en_out; a.opcode = opcode_out; a.funct = funct_out; a.shamt = shamt_out;
    return a;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input stim_t s);
    if (a == 5'd0) return 32'd0;
    if (s.ex_en && !s.ex_ld && s.ex_addr == a) return s.ex_data;
    if (s.wb_en && s.wb_addr == a) return s.wb_data;
    return rf[a];
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] im;
    op = s.instr[31:26]; fn = s.instr[5:0]; im = s.instr[15:0];
    e.pc   = s.pc;
    e.op_a = fwd(s.instr[25:21], s);
    e.op_b = fwd(s.instr[20:16], s);
    e.imm  = (op inside {[6'h0C:6'h0E]}) ? {16'h0000, im} : {{16{im[15]}}, im};
    if (op == 6'h00)      e.rd = s.instr[15:11];
    else if (op == 6'h03) e.rd = 5'd31;
    else                  e.rd = s.instr[20:16];
    e.wr = ((op == 6'h00 && fn != 6'h08) || op == 6'h03 ||
            (op inside {[6'h08:6'h0F], [6'h20:6'h25]})) && (e.rd != 5'd0);
    e.opcode = op; e.funct = fn; e.shamt = s.instr[10:6];
    return e;
  endfunction

  function automatic logic hazard(input stim_t s);
    logic [5:0] op;
    logic       urs;
    logic       urt;
    op  = s.instr[31:26];
    urs = !(op inside {6'h02, 6'h03, 6'h0F});
    urt = op inside {6'h00, 6'h04, 6'h05, [6'h28:6'h2B]};
    return s.valid && s.ex_en && s.ex_ld && (s.ex_addr != 5'd0) &&
           ((urs && s.ex_addr == s.instr[25:21]) || (urt && s.ex_addr == s.instr[20:16]));
  endfunction

  task automatic drive(input stim_t s);
    valid_in = s.valid;  instr_in = s.instr;     pc_in = s.pc;
    stall_in = s.stall;  flush = s.flush;
    ex_wr_en = s.ex_en;  ex_is_load = s.ex_ld;   ex_wr_addr = s.ex_addr; ex_wr_data = s.ex_data;
    wb_wr_en = s.wb_en;  wb_wr_addr = s.wb_addr; wb_wr_data = s.wb_data;
  endtask

  // One IF/ID cycle: drive, check combinational outputs, push the expected ID/EX load, then retire the WB write.
  task automatic step(input stim_t s);
    exp_t e;
    logic hz;
    @(negedge CLK);
    drive(s);
    #1;
    hz = hazard(s);
    chk("rf_read_addr", {rs_addr, rt_addr}, {s.instr[25:21], s.instr[20:16]});
    chk("stall_out", stall_out, hz);
    last_hz = hz;
    if (!s.stall) begin
      exp_valid = s.valid && !s.flush && !hz;
      if (exp_valid) begin
        e = model(s);
        q.push_back(e);
        last_exp = e;
      end
    end
    @(posedge CLK);
    #1;
    if (s.wb_en && s.wb_addr != 5'd0) rf[s.wb_addr] = s.wb_data;
  endtask

  function automatic stim_t mk(input logic [31:0] instr, input logic [31:0] pc);
    stim_t s = '0;
    s.valid = 1'b1; s.instr = instr; s.pc = pc;
    return s;
  endfunction

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    case ($urandom_range(0, 15))
      0, 1, 2, 3: op = 6'h00;
      4:          op = 6'h02;
      5:          op = 6'h03;
      6:          op = 6'h04;
      7:          op = 6'h05;
      8:          op = 6'h08;
      9:          op = 6'h0A;
      10:         op = 6'h0C;
      11:         op = 6'h0D;
      12:         op = 6'h0F;
      13:         op = 6'h23;
      14:         op = 6'h2B;
      default:    op = 6'($urandom_range(0, 63));
    endcase
    case ($urandom_range(0, 3))
      0:       fn = 6'h08;
      1:       fn = 6'h20;
      2:       fn = 6'h2A;
      default: fn = 6'($urandom);
    endcase
    return {op, rreg(), rreg(), rreg(), 5'($urandom), fn};
  endfunction

  initial begin : monitor
    logic loaded;
    forever begin
      @(posedge CLK);
      loaded = reset && !stall_in;
      #1;
      if (reset) begin
        chk("valid_out", valid_out, exp_valid);
        if (valid_out) begin
          if (loaded) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output: valid_out 1 with empty scoreboard, required none pending");
            end else begin
              chk("idex_fields", actual(), q.pop_front());
            end
          end else if (exp_valid) begin
            chk("held_fields", actual(), last_exp);
          end
        end
      end
    end
  end

  localparam logic [31:0] ADD_3_1_2 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] ADD_6_1_0 = {6'h00, 5'd1, 5'd0, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] ADD_6_0_1 = {6'h00, 5'd0, 5'd1, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] ADD_5_4_4 = {6'h00, 5'd4, 5'd4, 5'd5, 5'd0, 6'h20};
  localparam logic [31:0] ORI_2     = {6'h0D, 5'd0, 5'd2, 16'h8000};
  localparam logic [31:0] ADDI_2    = {6'h08, 5'd0, 5'd2, 16'hFFFF};
  localparam logic [31:0] JAL       = {6'h03, 26'h0000100};

  initial begin : main
    stim_t s;
    stim_t prev;
    reset = 1'b0;
    drive('0);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd7;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_valid", valid_out, 1'b0);
    chk("reset_fields", actual(), '0);
    @(negedge CLK);
    reset = 1'b1;

    step(mk(ADD_3_1_2, 32'h100));
    chk("add_op_a", op_a, 32'd5);
    chk("add_op_b", op_b, 32'd7);
    chk("add_rd_wr", {rd_out, wr_en_out}, {5'd3, 1'b1});

    s = mk(ADD_6_1_0, 32'h104);
    s.ex_en = 1'b1; s.ex_addr = 5'd1; s.ex_data = 32'h11;
    s.wb_en = 1'b1; s.wb_addr = 5'd1; s.wb_data = 32'h22;
    step(s);
    chk("fwd_ex_over_wb", op_a, 32'h11);
    s.ex_addr = 5'd7;
    step(s);
    chk("fwd_wb", op_a, 32'h22);
    s = mk(ADD_6_0_1, 32'h108);
    s.ex_en = 1'b1; s.ex_addr = 5'd0; s.ex_data = 32'h33;
    s.wb_en = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'h44;
    step(s);
    chk("fwd_reg0", op_a, 32'd0);

    s = mk(ADD_5_4_4, 32'h10C);
    s.ex_en = 1'b1; s.ex_ld = 1'b1; s.ex_addr = 5'd4; s.ex_data = 32'hDEAD;
    step(s);
    chk("load_use_bubble", valid_out, 1'b0);
    s.ex_en = 1'b0; s.ex_ld = 1'b0;
    s.wb_en = 1'b1; s.wb_addr = 5'd4; s.wb_data = 32'h4444;
    step(s);
    chk("load_use_issue", {valid_out, op_a, op_b}, {1'b1, 32'h4444, 32'h4444});

    step(mk(ORI_2, 32'h110));
    chk("ori_zext", imm_out, 32'h0000_8000);
    step(mk(ADDI_2, 32'h114));
    chk("addi_sext", imm_out, 32'hFFFF_FFFF);
    step(mk(JAL, 32'h118));
    chk("jal_link", {rd_out, wr_en_out}, {5'd31, 1'b1});

    s = mk(ADD_3_1_2, 32'h11C);
    s.flush = 1'b1; s.stall = 1'b1;
    step(s);
    chk("stall_over_flush", {valid_out, pc_out}, {1'b1, 32'h118});
    s.stall = 1'b0;
    step(s);
    chk("flush_bubble", valid_out, 1'b0);

    step(mk(ADD_3_1_2, 32'h200));
    #2;
    reset = 1'b0;
    drive('0);
    exp_valid = 1'b0;
    q.delete();
    #1;
    chk("midrun_reset_valid", valid_out, 1'b0);
    chk("midrun_reset_fields", actual(), '0);
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    step(mk(ADD_3_1_2, 32'h204));
    chk("post_reset_latency", {valid_out, pc_out}, {1'b1, 32'h204});

    prev = '0;
    for (int i = 0; i < 2000; i++) begin
      if (last_hz) begin
        s = prev;
        s.ex_en = 1'b0; s.ex_ld = 1'b0;
        s.wb_en = 1'b1; s.wb_addr = prev.ex_addr; s.wb_data = $urandom;
        s.stall = ($urandom_range(0, 9) == 0);
        s.flush = 1'b0;
      end else begin
        s.valid   = ($urandom_range(0, 6) != 0);
        s.instr   = rand_instr();
        s.pc      = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
        s.stall   = ($urandom_range(0, 9) == 0);
        s.flush   = ($urandom_range(0, 11) == 0);
        s.ex_en   = ($urandom_range(0, 9) < 6);
        s.ex_ld   = ($urandom_range(0, 3) == 0);
        s.ex_addr = rreg();
        s.ex_data = $urandom;
        s.wb_en   = ($urandom_range(0, 9) < 6);
        s.wb_addr = rreg();
        s.wb_data = $urandom;
      end
      step(s);
      prev = s;
    end

    step('0);
    step('0);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
